// File: rtl/time_keeper.sv
// BCD HH:MM:SS time-of-day counter driven by the tick_gen 1 Hz / 5 Hz ticks.
// Hold set_hours / set_minutes to edit a field; the 5 Hz tick auto-repeats while held.
module time_keeper #(
  parameter bit HOURS_24 = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       tick_5Hz,
  input  logic       set_hours,
  input  logic       set_minutes,
  output logic [3:0] hour_tens,
  output logic [3:0] hour_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [1:0] mode,
  output logic       sec_strobe
);

  // state    | meaning
  // ST_RUN   | time advances on 1 Hz rises
  // ST_SET_H | hours edited on 5 Hz rises, time frozen
  // ST_SET_M | minutes edited on 5 Hz rises, time frozen
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  localparam logic [3:0] HT_RST = HOURS_24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HO_RST = HOURS_24 ? 4'd0 : 4'd2;

  state_t     r_state, w_state;
  logic       r_tick1_q, r_tick5_q;
  logic [3:0] r_ht, r_ho, r_mt, r_mo, r_st, r_so;
  logic [3:0] w_ht, w_ho, w_mt, w_mo, w_st, w_so;
  logic       r_strobe, w_strobe;
  logic       w_rise1, w_rise5;
  logic [8:0] w_sec_inc, w_min_inc;
  logic [7:0] w_hour_inc;

  // Returns {carry, tens, ones} for a 00..59 field.
  function automatic logic [8:0] f_inc_60(input logic [3:0] t, input logic [3:0] o);
    if (o == 4'd9) begin
      if (t == 4'd5) f_inc_60 = {1'b1, 4'd0, 4'd0};
      else           f_inc_60 = {1'b0, t + 4'd1, 4'd0};
    end else begin
      f_inc_60 = {1'b0, t, o + 4'd1};
    end
  endfunction

  function automatic logic [7:0] f_inc_hour(input logic [3:0] t, input logic [3:0] o);
    if (HOURS_24 && t == 4'd2 && o == 4'd3)       f_inc_hour = {4'd0, 4'd0};
    else if (!HOURS_24 && t == 4'd1 && o == 4'd2) f_inc_hour = {4'd0, 4'd1};
    else if (o == 4'd9)                           f_inc_hour = {t + 4'd1, 4'd0};
    else                                          f_inc_hour = {t, o + 4'd1};
  endfunction

  assign w_rise1    = tick_1Hz & ~r_tick1_q;
  assign w_rise5    = tick_5Hz & ~r_tick5_q;
  assign w_sec_inc  = f_inc_60(r_st, r_so);
  assign w_min_inc  = f_inc_60(r_mt, r_mo);
  assign w_hour_inc = f_inc_hour(r_ht, r_ho);

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state   <= ST_RUN;
      r_tick1_q <= 1'b1;
      r_tick5_q <= 1'b1;
      r_ht      <= HT_RST;
      r_ho      <= HO_RST;
      r_mt      <= 4'd0;
      r_mo      <= 4'd0;
      r_st      <= 4'd0;
      r_so      <= 4'd0;
      r_strobe  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tick1_q <= tick_1Hz;
      r_tick5_q <= tick_5Hz;
      r_ht      <= w_ht;
      r_ho      <= w_ho;
      r_mt      <= w_mt;
      r_mo      <= w_mo;
      r_st      <= w_st;
      r_so      <= w_so;
      r_strobe  <= w_strobe;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_ht     = r_ht;
    w_ho     = r_ho;
    w_mt     = r_mt;
    w_mo     = r_mo;
    w_st     = r_st;
    w_so     = r_so;
    w_strobe = 1'b0;
    case (r_state)
      ST_RUN: begin
        // A button press on the same edge as a 1 Hz rise swallows that second.
        if (set_hours) begin
          w_state      = ST_SET_H;
          {w_ht, w_ho} = w_hour_inc;
        end else if (set_minutes) begin
          w_state      = ST_SET_M;
          {w_mt, w_mo} = w_min_inc[7:0];
          w_st         = 4'd0;
          w_so         = 4'd0;
        end else if (w_rise1) begin
          w_strobe     = 1'b1;
          {w_st, w_so} = w_sec_inc[7:0];
          if (w_sec_inc[8]) begin
            {w_mt, w_mo} = w_min_inc[7:0];
            if (w_min_inc[8]) {w_ht, w_ho} = w_hour_inc;
          end
        end
      end
      ST_SET_H: begin
        if (!set_hours)   w_state      = ST_RUN;
        else if (w_rise5) {w_ht, w_ho} = w_hour_inc;
      end
      ST_SET_M: begin
        if (!set_minutes) w_state      = ST_RUN;
        else if (w_rise5) {w_mt, w_mo} = w_min_inc[7:0];
      end
      default: w_state = ST_RUN;
    endcase
  end

  assign hour_tens  = r_ht;
  assign hour_ones  = r_ho;
  assign min_tens   = r_mt;
  assign min_ones   = r_mo;
  assign sec_tens   = r_st;
  assign sec_ones   = r_so;
  assign mode       = r_state;
  assign sec_strobe = r_strobe;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: a table of single-cycle vectors plus
// hand-written sequences for preloads, rollovers, long holds and reset during set.
module tb_time_keeper;

  logic clk_in = 1'b0;
  logic reset = 1'b0;
  logic tick_1Hz = 1'b0, tick_5Hz = 1'b0, set_hours = 1'b0, set_minutes = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic [1:0] a_mode;
  logic       a_strb;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic [1:0] b_mode;
  logic       b_strb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_in = ~clk_in;

  time_keeper #(.HOURS_24(1'b1)) dut_24 (
    .clk_in(clk_in), .reset(reset), .tick_1Hz(tick_1Hz), .tick_5Hz(tick_5Hz),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .hour_tens(a_ht), .hour_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .mode(a_mode), .sec_strobe(a_strb));

  time_keeper #(.HOURS_24(1'b0)) dut_12 (
    .clk_in(clk_in), .reset(reset), .tick_1Hz(tick_1Hz), .tick_5Hz(tick_5Hz),
    .set_hours(set_hours), .set_minutes(set_minutes),
    .hour_tens(b_ht), .hour_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .mode(b_mode), .sec_strobe(b_strb));

  typedef struct packed {
    logic        rst_n, t1, t5, sh, sm;
    logic [23:0] dig;
    logic [1:0]  mode;
    logic        strb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, input logic t1, input logic t5,
                              input logic sh, input logic sm, input logic [23:0] dig,
                              input logic [1:0] mode, input logic strb);
    mk = '{rst_n: rst_n, t1: t1, t5: t5, sh: sh, sm: sm, dig: dig, mode: mode, strb: strb};
  endfunction

  function automatic logic [26:0] obs_a();
    obs_a = {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_mode, a_strb};
  endfunction

  function automatic logic [26:0] obs_b();
    obs_b = {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_mode, b_strb};
  endfunction

  // Values shown as {HHMMSS digits, mode, strobe}.
  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got time=%h mode=%b strobe=%b, expected time=%h mode=%b strobe=%b",
                  name, act[26:3], act[2:1], act[0], exp[26:3], exp[2:1], exp[0]);
  endtask

  task automatic step(input logic rst_n, input logic t1, input logic t5,
                      input logic sh, input logic sm);
    reset = rst_n; tick_1Hz = t1; tick_5Hz = t5; set_hours = sh; set_minutes = sm;
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse5(input logic sh, input logic sm, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b1, sh, sm);
      step(1'b1, 1'b0, 1'b0, sh, sm);
    end
  endtask

  task automatic pulse1(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Set hours: entry +1 then n 5 Hz rises; release takes one cycle back to RUN.
  task automatic set_h(input int n);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    pulse5(1'b1, 1'b0, n);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_m(input int n);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse5(1'b0, 1'b1, n);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //                 rst t1 t5 sh sm   HHMMSS       mode  strb
    vecs.push_back(mk(0, 0, 0, 0, 0, 24'h000000, 2'b00, 0)); // reset
    vecs.push_back(mk(0, 1, 0, 0, 0, 24'h000000, 2'b00, 0)); // tick high in reset
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000000, 2'b00, 0)); // release, tick still high
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h000000, 2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000001, 2'b00, 1)); // 1st second
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000001, 2'b00, 0)); // held, no repeat
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h000001, 2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000002, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h000002, 2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h000003, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h000003, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 24'h010003, 2'b01, 0)); // both buttons: hours win
    vecs.push_back(mk(1, 1, 0, 1, 1, 24'h010003, 2'b01, 0)); // 1 Hz frozen
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h010003, 2'b00, 0)); // release
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h010003, 2'b00, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h020003, 2'b01, 0)); // SET_H entry
    vecs.push_back(mk(1, 0, 1, 1, 0, 24'h030003, 2'b01, 0)); // 5 Hz rise
    vecs.push_back(mk(1, 0, 1, 1, 0, 24'h030003, 2'b01, 0)); // held
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h030003, 2'b01, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 24'h040003, 2'b01, 0)); // 1 Hz + 5 Hz together
    vecs.push_back(mk(1, 0, 0, 1, 0, 24'h040003, 2'b01, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h040003, 2'b00, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 24'h040100, 2'b10, 0)); // entry + 5 Hz: single inc
    vecs.push_back(mk(1, 0, 0, 0, 1, 24'h040100, 2'b10, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 24'h040100, 2'b10, 0)); // other button ignored
    vecs.push_back(mk(1, 0, 1, 0, 1, 24'h040200, 2'b10, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 24'h040200, 2'b10, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 24'h040200, 2'b00, 0)); // exit edge, no inc
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h040201, 2'b00, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h040201, 2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 24'h050201, 2'b01, 0)); // press beats 1 Hz rise
    vecs.push_back(mk(1, 0, 0, 0, 0, 24'h050201, 2'b00, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 24'h050202, 2'b00, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].t1, vecs[i].t5, vecs[i].sh, vecs[i].sm);
      chk($sformatf("vec%0d", i), obs_a(), {vecs[i].dig, vecs[i].mode, vecs[i].strb});
    end

    // 12 h reset value
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_12h", obs_b(), {24'h120000, 2'b00, 1'b0});

    // Edit minutes from 10:58:30
    do_reset();
    set_h(9);
    set_m(57);
    pulse1(30);
    chk("preload_105830", obs_a(), {24'h105830, 2'b00, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("setm_entry", obs_a(), {24'h105900, 2'b10, 1'b0});
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("setm_1hz_frozen", obs_a(), {24'h105900, 2'b10, 1'b0});
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("setm_wrap_59_00", obs_a(), {24'h100000, 2'b10, 1'b0});
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("setm_5hz_over_1hz", obs_a(), {24'h100100, 2'b10, 1'b0});

    // 24 h full rollover 23:59:59 -> 00:00:00
    do_reset();
    set_h(22);
    set_m(58);
    pulse1(59);
    chk("preload_235959", obs_a(), {24'h235959, 2'b00, 1'b0});
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rollover_24h", obs_a(), {24'h000000, 2'b00, 1'b1});
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("strobe_single", obs_a(), {24'h000000, 2'b00, 1'b0});

    // 12 h rollover 12:59:59 -> 01:00:00 (entry 12->01, 11 rises pass 11->12)
    do_reset();
    set_h(11);
    set_m(58);
    pulse1(59);
    chk("preload_125959", obs_b(), {24'h125959, 2'b00, 1'b0});
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rollover_12h", obs_b(), {24'h010000, 2'b00, 1'b1});

    // 1 Hz held high for 50 cycles
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("hold_1hz_50", obs_a(), {24'h000001, 2'b00, 1'b0});

    // Reset during SET_M at 07:42:00
    do_reset();
    set_h(6);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse5(1'b0, 1'b1, 41);
    chk("setm_074200", obs_a(), {24'h074200, 2'b10, 1'b0});
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset_in_setm", obs_a(), {24'h000000, 2'b00, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
